// File: rtl/fpu_aligner.sv
// fpu_aligner: right-shifts an operand mantissa until its exponent matches a
// target exponent, one bit per cycle, collecting guard/round/sticky bits
// for the rounding stage that follows.
module fpu_aligner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [22:0] mantissa_in,
  input  logic [7:0]  exponent_in,
  input  logic [7:0]  target_exponent,
  output logic        busy,
  output logic        done,
  output logic [23:0] aligned_mantissa,
  output logic [7:0]  aligned_exponent,
  output logic        guard,
  output logic        round_bit,
  output logic        sticky,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  shift_count;

  logic [7:0]  effective_exp;
  logic        hidden_bit;
  logic        underflow;
  logic [7:0]  exp_diff;
  logic [4:0]  clamped_shift;

  // Decode the incoming operand: denormals use exponent 1 with no hidden bit,
  // and any shift past 26 gives the same result, so the count is saturated.
  always_comb begin
    hidden_bit    = (exponent_in != 8'd0);
    effective_exp = hidden_bit ? exponent_in : 8'd1;
    underflow     = (target_exponent < effective_exp);
    exp_diff      = target_exponent - effective_exp;
    clamped_shift = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
  end

  // Control FSM and datapath; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      shift_count      <= 5'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      aligned_mantissa <= 24'd0;
      aligned_exponent <= 8'd0;
      guard            <= 1'b0;
      round_bit        <= 1'b0;
      sticky           <= 1'b0;
      error            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            aligned_mantissa <= {hidden_bit, mantissa_in};
            guard            <= 1'b0;
            round_bit        <= 1'b0;
            sticky           <= 1'b0;
            busy             <= 1'b1;
            if (underflow) begin
              error            <= 1'b1;
              aligned_exponent <= effective_exp;
              shift_count      <= 5'd0;
              done             <= 1'b1;
              state            <= DONE;
            end else begin
              error            <= 1'b0;
              aligned_exponent <= target_exponent;
              shift_count      <= clamped_shift;
              if (clamped_shift == 5'd0) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= SHIFT;
              end
            end
          end
        end

        SHIFT: begin
          sticky           <= sticky | round_bit;
          round_bit        <= guard;
          guard            <= aligned_mantissa[0];
          aligned_mantissa <= aligned_mantissa >> 1;
          shift_count      <= shift_count - 5'd1;
          if (shift_count == 5'd1) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_aligner.sv
// tb_fpu_aligner: directed vectors for fpu_aligner, checked against a
// cycle-level behavioural model and hand-computed expected values.
module tb_fpu_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [22:0] mantissa_in = 23'd0;
  logic [7:0]  exponent_in = 8'd0;
  logic [7:0]  target_exponent = 8'd0;
  logic        busy, done, guard, round_bit, sticky, error;
  logic [23:0] aligned_mantissa;
  logic [7:0]  aligned_exponent;

  int tests = 0;
  int fails = 0;

  fpu_aligner dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .mantissa_in      (mantissa_in),
    .exponent_in      (exponent_in),
    .target_exponent  (target_exponent),
    .busy             (busy),
    .done             (done),
    .aligned_mantissa (aligned_mantissa),
    .aligned_exponent (aligned_exponent),
    .guard            (guard),
    .round_bit        (round_bit),
    .sticky           (sticky),
    .error            (error)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Ideal alignment: place the mantissa in a wide field, shift by k, and read
  // the kept bits, the two bits below them, and the OR of everything lower.
  function automatic void modelAlign(input logic [22:0] mant, input logic [7:0] ex,
                                     input logic [7:0] tgt, output logic [23:0] m,
                                     output logic [7:0] e, output logic g, output logic r,
                                     output logic s, output logic err, output int k);
    int          eff;
    logic [23:0] m0;
    logic [49:0] wide;
    eff = (ex == 8'd0) ? 1 : int'(ex);
    m0  = {(ex != 8'd0), mant};
    if (int'(tgt) < eff) begin
      err = 1'b1; k = 0; m = m0; e = 8'(eff); g = 1'b0; r = 1'b0; s = 1'b0;
    end else begin
      err = 1'b0;
      k   = int'(tgt) - eff;
      if (k > 26) k = 26;
      wide = {m0, 26'd0} >> k;
      m = wide[49:26]; g = wide[25]; r = wide[24]; s = |wide[23:0];
      e = tgt;
    end
  endfunction

  // Model: rem counts cycles left in the current operation (1 = done cycle)
  int          rem = 0;
  logic [23:0] exp_m = 24'd0;
  logic [7:0]  exp_e = 8'd0;
  logic        exp_g = 1'b0, exp_r = 1'b0, exp_s = 1'b0, exp_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [23:0] m;
    logic [7:0]  e;
    logic        g, r, s, err;
    int          k;
    if (!rst_n) begin
      rem <= 0; exp_m <= 24'd0; exp_e <= 8'd0;
      exp_g <= 1'b0; exp_r <= 1'b0; exp_s <= 1'b0; exp_err <= 1'b0;
    end else if (rem == 0) begin
      if (start) begin
        modelAlign(mantissa_in, exponent_in, target_exponent, m, e, g, r, s, err, k);
        rem <= k + 1;
        exp_m <= m; exp_e <= e; exp_g <= g; exp_r <= r; exp_s <= s; exp_err <= err;
      end
    end else begin
      rem <= rem - 1;
    end
  end

  // Compare the DUT against the model on every falling edge
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(rem > 0));
    check("done", 32'(done), 32'(rem == 1));
    if (rem <= 1) begin
      check("model_mantissa", 32'(aligned_mantissa), 32'(exp_m));
      check("model_exponent", 32'(aligned_exponent), 32'(exp_e));
      check("model_grs", 32'({guard, round_bit, sticky}), 32'({exp_g, exp_r, exp_s}));
      check("model_error", 32'(error), 32'(exp_err));
    end
  end

  task automatic waitDone(input int pulse, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      start = (lat == pulse);
      if (done) break;
      if (lat >= 60) begin
        check("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int lat, input int exp_lat,
                             input logic [23:0] m, input logic [7:0] e,
                             input logic g, input logic r, input logic s, input logic err);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_mantissa"}, 32'(aligned_mantissa), 32'(m));
    check({name, "_exponent"}, 32'(aligned_exponent), 32'(e));
    check({name, "_guard"}, 32'(guard), 32'(g));
    check({name, "_round"}, 32'(round_bit), 32'(r));
    check({name, "_sticky"}, 32'(sticky), 32'(s));
    check({name, "_error"}, 32'(error), 32'(err));
  endtask

  task automatic applyStimulus(input string name, input logic [22:0] mant,
                               input logic [7:0] ex, input logic [7:0] tgt, input int pulse,
                               input int exp_lat, input logic [23:0] m, input logic [7:0] e,
                               input logic g, input logic r, input logic s, input logic err);
    int lat;
    @(posedge clk);
    #2;
    mantissa_in = mant; exponent_in = ex; target_exponent = tgt; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    waitDone(pulse, lat);
    checkOutput(name, lat, exp_lat, m, e, g, r, s, err);
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  initial begin : stimulus
    int lat;
    int done_count;
    #1 rst_n = 1'b0;
    #20;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mantissa", 32'(aligned_mantissa), 32'd0);
    check("reset_exponent", 32'(aligned_exponent), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("k0", 23'h000000, 8'd127, 8'd127, 0, 1, 24'h800000, 8'd127, 0, 0, 0, 0);
    applyStimulus("k2", 23'h000003, 8'd100, 8'd102, 0, 3, 24'h200000, 8'd102, 1, 1, 0, 0);
    applyStimulus("denorm_k0", 23'h400000, 8'd0, 8'd1, 0, 1, 24'h400000, 8'd1, 0, 0, 0, 0);
    applyStimulus("clamp", 23'h000000, 8'd10, 8'd200, 5, 27, 24'h000000, 8'd200, 0, 0, 1, 0);
    applyStimulus("underflow", 23'h123456, 8'd50, 8'd40, 1, 1, 24'h923456, 8'd50, 0, 0, 0, 1);
    applyStimulus("k3_ones", 23'h7FFFFF, 8'd127, 8'd130, 0, 4, 24'h1FFFFF, 8'd130, 1, 1, 1, 0);
    applyStimulus("denorm_k2", 23'h000005, 8'd0, 8'd3, 0, 3, 24'h000001, 8'd3, 0, 1, 0, 0);

    // Start held high: a k=1 operation restarts every 3 cycles
    @(posedge clk);
    #2;
    mantissa_in = 23'h000001; exponent_in = 8'd127; target_exponent = 8'd128; start = 1'b1;
    done_count = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    start = 1'b0;
    check("b2b_done_count", 32'(done_count), 32'd3);
    repeat (4) @(negedge clk);

    // Reset in the middle of a long shift
    @(posedge clk);
    #2;
    mantissa_in = 23'h000001; exponent_in = 8'd10; target_exponent = 8'd30; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_mantissa", 32'(aligned_mantissa), 32'd0);
    check("abort_exponent", 32'(aligned_exponent), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mantissa_in = 23'h000002; exponent_in = 8'd127; target_exponent = 8'd128; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    waitDone(0, lat);
    checkOutput("after_reset", lat, 2, 24'h400001, 8'd128, 0, 0, 0, 0);
    @(posedge clk);
    #2 start = 1'b0;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
